// File: rtl/asm_deinterleaver.sv
// asm_deinterleaver
//   Receive-side inverse of the ASM bit interleaver. Serial interleaved bits
//   are scattered into a two-bank ping-pong buffer at their natural-order
//   addresses. Each frame is then read back in natural order, one bit per
//   request. The permutation p(k) = (A*k + B) mod N is chosen by link_id,
//   which is sampled on the first bit of each frame.
// Ports
//   clk, rst    : clock and asynchronous active-high reset
//   link_id     : permutation select, sampled on bit 0 of a frame
//   din/din_vld : interleaved serial input
//   request     : read request, one natural-order bit per high cycle
//   dout/dout_vld : deinterleaved bit, one cycle after the request
//   frame_done  : pulses together with dout_vld of the last bit of a frame
//   overflow    : pulses one cycle after a din_vld that was dropped
//   busy        : at least one bank holds or is receiving frame data
module asm_deinterleaver #(
  parameter int ADDR_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] link_id,
  input  logic       din,
  input  logic       din_vld,
  input  logic       request,
  output logic       dout,
  output logic       dout_vld,
  output logic       frame_done,
  output logic       overflow,
  output logic       busy
);

  localparam int N = 2 ** ADDR_W;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

  bank_st_t          bank_st  [2];
  bank_st_t          bank_nxt [2];
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] r;
  logic [ADDR_W-1:0] a_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              mem [2][N];

  logic [ADDR_W-1:0] a_id;
  logic [ADDR_W-1:0] b_id;
  logic [ADDR_W-1:0] cur_a;
  logic [ADDR_W-1:0] cur_addr;
  logic              wr_open;
  logic              wr_acc;
  logic              wr_last;
  logic              rd_ok;
  logic              rd_last;

  // A is forced odd so the map is a bijection; both are reduced mod N by truncation.
  assign a_id = ADDR_W'({link_id, 1'b1});
  assign b_id = ADDR_W'({link_id, 2'b00});

  // Bit 0 of a frame uses the live link_id. Later bits use the latched step.
  // This is why link_id changes mid-frame have no effect.
  assign cur_addr = (k == '0) ? b_id : addr_reg;
  assign cur_a    = (k == '0) ? a_id : a_reg;

  assign wr_open = (bank_st[wr_bank] == EMPTY) || (bank_st[wr_bank] == FILLING);
  assign wr_acc  = din_vld && wr_open;
  assign wr_last = wr_acc && (&k);
  assign rd_ok   = request && ((bank_st[rd_bank] == FULL) || (bank_st[rd_bank] == DRAINING));
  assign rd_last = rd_ok && (&r);

  // Bank state machine: next-state logic.
  // The write pointer only touches EMPTY or FILLING banks. The read pointer
  // only touches FULL or DRAINING banks. Both may therefore update in the
  // same cycle without conflict.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bank_nxt[i] = bank_st[i];
      if (wr_acc && (wr_bank == 1'(i)))
        bank_nxt[i] = wr_last ? FULL : FILLING;
      if (rd_ok && (rd_bank == 1'(i)))
        bank_nxt[i] = rd_last ? EMPTY : DRAINING;
    end
  end

  // Bank state machine: outputs.
  always_comb begin
    busy = (bank_st[0] != EMPTY) || (bank_st[1] != EMPTY);
  end

  // Registered stage: bank states, pointers and the read-out register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      k          <= '0;
      r          <= '0;
      a_reg      <= '0;
      addr_reg   <= '0;
      dout       <= 1'b0;
      dout_vld   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      bank_st[0] <= bank_nxt[0];
      bank_st[1] <= bank_nxt[1];
      overflow   <= din_vld && !wr_open;
      dout_vld   <= rd_ok;
      frame_done <= rd_last;
      if (wr_acc) begin
        k        <= k + ADDR_W'(1);
        addr_reg <= cur_addr + cur_a;
        if (k == '0)
          a_reg <= a_id;
        if (wr_last)
          wr_bank <= ~wr_bank;
      end
      if (rd_ok) begin
        r    <= r + ADDR_W'(1);
        dout <= mem[rd_bank][r];
        if (rd_last)
          rd_bank <= ~rd_bank;
      end
    end
  end

  // Frame storage. It is not cleared on reset; bank states gate every access.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_bank][cur_addr] <= din;
  end

endmodule
